// File: rtl/sc_mem_pkg.sv
// Shared definitions for the data-memory port: access size codes, FSM state
// type, byte-lane enable width and the small decode helpers built on them.
package sc_mem_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  // A request is misaligned when its low address bits do not fit its size;
  // the reserved size code is always rejected.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Little-endian byte-lane enables for a store of the given size.
  function automatic logic [BE_W-1:0] byte_en(logic [1:0] size, logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sc_dmem_port_if.sv
// CPU-side bus of the data-memory port. The CPU drives the request fields
// (master); the memory port returns the load result and status (slave).
interface sc_dmem_port_if;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        addr_err;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ack, busy, addr_err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ack, busy, addr_err
  );

endinterface

// File: rtl/sc_dmem_lane.sv
// Load-side lane steering: selects the addressed byte or half of a memory
// word, right-aligns it and sign- or zero-extends it. Word loads pass through.
module sc_dmem_lane
  import sc_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] word,
  output logic [31:0] rdata_next
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // pick the addressed lane and widen it to a full word
  always_comb begin
    lane_b = word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: rdata_next = {{24{sign_ext & lane_b[7]}}, lane_b};
      SZ_HALF: rdata_next = {{16{sign_ext & lane_h[15]}}, lane_h};
      default: rdata_next = word;
    endcase
  end

endmodule

// File: rtl/sc_dmem_port.sv
// Single-port data memory with a fixed wait-state count. Requests are taken
// only in IDLE; legal accesses spend LATENCY cycles in WAIT, illegal ones go
// straight to DONE with addr_err. Stores and loads both complete on the
// WAIT->DONE edge, so an access aborted by reset leaves no trace.
module sc_dmem_port
  import sc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic           clk,
  input logic           rst_n,
  sc_dmem_port_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic              cap_sext;
  logic [1:0]        cap_size;
  logic [1:0]        cap_lo;
  logic [IDX_W-1:0]  cap_idx;
  logic [31:0]       cap_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              illegal;
  logic              commit;
  logic [BE_W-1:0]   be;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rdata_next;

  logic [31:0]       rdata_q;
  logic              ack_q;
  logic              busy_q;
  logic              err_q;

  assign illegal = misaligned(bus.size, bus.addr[1:0]) ||
                   ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS));
  assign commit  = (state == WAIT) && (cnt == 4'd0);
  assign be      = byte_en(cap_size, cap_lo);

  // replicate the low store bits across every lane so the enables pick them
  always_comb begin
    case (cap_size)
      SZ_BYTE: wdata_lanes = {4{cap_wdata[7:0]}};
      SZ_HALF: wdata_lanes = {2{cap_wdata[15:0]}};
      default: wdata_lanes = cap_wdata;
    endcase
  end

  sc_dmem_lane u_lane (
    .addr_lo    (cap_lo),
    .size       (cap_size),
    .sign_ext   (cap_sext),
    .word       (mem[cap_idx]),
    .rdata_next (rdata_next)
  );

  // control FSM: capture on accept, count down the wait, pulse ack, latch load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      cap_we    <= 1'b0;
      cap_sext  <= 1'b0;
      cap_size  <= 2'b00;
      cap_lo    <= 2'b00;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.req) begin
            cap_we    <= bus.we;
            cap_sext  <= bus.sign_ext;
            cap_size  <= bus.size;
            cap_lo    <= bus.addr[1:0];
            cap_idx   <= bus.addr[IDX_W+1:2];
            cap_wdata <= bus.wdata;
            busy_q    <= 1'b1;
            if (illegal) begin
              state <= DONE;
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            ack_q <= 1'b1;
            err_q <= 1'b0;
            if (!cap_we) begin
              rdata_q <= rdata_next;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // store commit: merge the enabled byte lanes on the WAIT->DONE edge
  always_ff @(posedge clk) begin
    if (commit && cap_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[cap_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.addr_err = err_q;

endmodule

// File: doc/sc_dmem_port.md
SC_DMEM_PORT -- requirements
Module: sc_dmem_port

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning number of 32-bit words in the internal data memory.
REQ-002 SHALL have parameter LATENCY, default 2, meaning WAIT cycles per access; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port sign_ext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data; the value is in the low bits.
REQ-011 SHALL have port rdata  output  32  load result, registered; feeds the CPU data register.
REQ-012 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port addr_err  output  1  valid with ack; 1 = access rejected.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 In IDLE, on a posedge clk with req=1, the block SHALL capture addr, we, size, sign_ext and wdata.
REQ-017 On an accepted legal request, the block SHALL load the counter with LATENCY-1 and go to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at a count of 0 the next edge SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-020 ack SHALL be 1 only while in DONE.
REQ-021 A legal access SHALL show ack exactly LATENCY+1 cycles after the accept edge's cycle.
REQ-022 A request SHALL be illegal if size=11, if a half access has addr[0]=1, or if a word access has addr[1:0]!=0.
REQ-023 A request SHALL be illegal if addr[31:2] >= DEPTH_WORDS.
REQ-024 An illegal request SHALL go straight from IDLE to DONE with addr_err=1 (ack one cycle after accept).
REQ-025 An illegal request SHALL cause no memory write and SHALL leave rdata unchanged.
REQ-026 A store SHALL commit on the WAIT->DONE edge.
REQ-027 A store SHALL update only the addressed byte lanes: byte lane = addr[1:0]; half lanes = addr[1]; little-endian.
REQ-028 A load SHALL update rdata on the WAIT->DONE edge with the selected lane, right-aligned and extended per sign_ext.
REQ-029 A word load SHALL ignore sign_ext.
REQ-030 rdata SHALL hold its value until the next successful load; stores SHALL NOT change it.
REQ-031 req SHALL be ignored while busy=1, including during the DONE cycle.
REQ-032 Back-to-back accesses SHALL accept the next request no earlier than the IDLE cycle following DONE.
REQ-033 addr_err SHALL be 0 whenever ack=0.

Reset
REQ-034 When rst_n=0, the block SHALL immediately force state IDLE, counter 0, ack 0, busy 0, addr_err 0 and rdata 0.
REQ-035 Reset asserted before the WAIT->DONE edge SHALL abort the access with no memory write and no ack.
REQ-036 Memory contents SHALL NOT be reset; the simulation initial value SHALL be all-zero.

Structure
REQ-037 Shared package sc_mem_pkg SHALL hold the size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the FSM state type and the byte-lane enable width.
REQ-038 Lane steering and extension SHALL live in one combinational sub-module, sc_dmem_lane, with inputs addr[1:0], size, sign_ext and word and output rdata_next.
REQ-039 The memory array, FSM and counter SHALL remain in sc_dmem_port.

Verification (LATENCY=2, DEPTH_WORDS=64)
REQ-040 Scenario: word store 0xDEADBEEF @0x10, then word load @0x10 -> ack LATENCY+1 cycles after each accept, rdata=0xDEADBEEF, addr_err=0.
REQ-041 Scenario: byte load @0x13, sign_ext=1, after the above -> rdata=0xFFFFFFDE; with sign_ext=0 -> 0x000000DE.
REQ-042 Scenario: half store 0x1234 @0x12, then word load @0x10 -> rdata=0x1234BEEF.
REQ-043 Scenario: word load @0x102, then half load @0x01, then word load @0x100 (index 64) -> each gives ack one cycle after accept with addr_err=1, rdata unchanged, memory unchanged.
REQ-044 Scenario: req held high continuously -> accepts are spaced exactly LATENCY+2 cycles apart; busy is low for only one cycle between accesses.
REQ-045 Scenario: rst_n pulsed low mid-WAIT of a store 0xCAFEF00D @0x20 -> outputs zero asynchronously, no ack, and a later load @0x20 returns the prior value.
